// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: arbitrates three writeback requesters onto the register-file write port and tracks pending writes for decode hazards
module regfile_wb_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic [4:0]  mem_addr,
  input  logic [31:0] mem_data,
  output logic        mem_ready,
  input  logic        alu_valid,
  input  logic [4:0]  alu_addr,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        md_valid,
  input  logic [4:0]  md_addr,
  input  logic [31:0] md_data,
  output logic        md_ready,
  output logic        RegWE,
  output logic [4:0]  write_addr,
  output logic [31:0] write_data,
  input  logic        issue_valid,
  input  logic [4:0]  issue_addr,
  output logic        issue_full,
  input  logic [4:0]  read_addr1,
  input  logic [4:0]  read_addr2,
  output logic [1:0]  pause
);
  localparam logic [2:0] LIM = 3'(STARVE_LIMIT);
  logic [2:0]  vld, starved, gnt;
  logic [2:0]  wait_q [3];
  logic [2:0]  wait_d [3];
  logic [1:0]  cnt_q [32];
  logic [1:0]  cnt_d [32];
  logic        we_q, we_d, inc_ok;
  logic [4:0]  addr_q, sel_addr;
  logic [31:0] data_q, sel_data;
  assign vld = {md_valid, alu_valid, mem_valid};
  // starved requesters win, and among them the slowest-draining unit (md) goes first
  always_comb begin
    for (int k = 0; k < 3; k++) starved[k] = vld[k] && wait_q[k] == LIM;
    gnt = |starved ? (starved[2] ? 3'b100 : starved[1] ? 3'b010 : 3'b001)
                   : (vld[0] ? 3'b001 : vld[1] ? 3'b010 : vld[2] ? 3'b100 : 3'b000);
    for (int k = 0; k < 3; k++)
      wait_d[k] = (vld[k] && !gnt[k]) ? (wait_q[k] == LIM ? LIM : wait_q[k] + 3'd1) : 3'd0;
  end
  assign {md_ready, alu_ready, mem_ready} = gnt;
  assign sel_addr = gnt[0] ? mem_addr : gnt[1] ? alu_addr : md_addr;
  assign sel_data = gnt[0] ? mem_data : gnt[1] ? alu_data : md_data;
  assign we_d     = |gnt && sel_addr != 5'd0;
  assign inc_ok   = issue_valid && issue_addr != 5'd0 && cnt_q[issue_addr] != 2'd3;
  always_comb begin
    cnt_d[0] = 2'd0;
    for (int i = 1; i < 32; i++) begin
      cnt_d[i] = cnt_q[i];
      if (inc_ok && issue_addr == 5'(i) && !(we_q && addr_q == 5'(i) && cnt_q[i] != 2'd0))
        cnt_d[i] = cnt_q[i] + 2'd1;
      else if (!(inc_ok && issue_addr == 5'(i)) && we_q && addr_q == 5'(i) && cnt_q[i] != 2'd0)
        cnt_d[i] = cnt_q[i] - 2'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      we_q   <= 1'b0;
      addr_q <= 5'd0;
      data_q <= 32'd0;
      for (int k = 0; k < 3; k++) wait_q[k] <= 3'd0;
      for (int i = 0; i < 32; i++) cnt_q[i] <= 2'd0;
    end else begin
      we_q <= we_d;
      if (we_d) begin
        addr_q <= sel_addr;
        data_q <= sel_data;
      end
      for (int k = 0; k < 3; k++) wait_q[k] <= wait_d[k];
      for (int i = 0; i < 32; i++) cnt_q[i] <= cnt_d[i];
    end
  end
  assign RegWE      = we_q;
  assign write_addr = addr_q;
  assign write_data = data_q;
  assign issue_full = issue_addr != 5'd0 && cnt_q[issue_addr] == 2'd3;
  assign pause = {read_addr2 != 5'd0 && cnt_q[read_addr2] != 2'd0,
                  read_addr1 != 5'd0 && cnt_q[read_addr1] != 2'd0};
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed tests of arbitration, starvation promotion and the pending-write scoreboard
module tb_regfile_wb_arbiter;
  logic clk = 0, rst = 0;
  logic mem_valid = 0, alu_valid = 0, md_valid = 0;
  logic [4:0] mem_addr = 0, alu_addr = 0, md_addr = 0;
  logic [31:0] mem_data = 0, alu_data = 0, md_data = 0;
  logic mem_ready, alu_ready, md_ready, RegWE, issue_full;
  logic [4:0] write_addr, issue_addr = 0, read_addr1 = 0, read_addr2 = 0;
  logic [31:0] write_data;
  logic issue_valid = 0;
  logic [1:0] pause;
  int errors = 0, checks = 0;

  regfile_wb_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .md_valid(md_valid), .md_addr(md_addr), .md_data(md_data), .md_ready(md_ready),
    .RegWE(RegWE), .write_addr(write_addr), .write_data(write_data),
    .issue_valid(issue_valid), .issue_addr(issue_addr), .issue_full(issue_full),
    .read_addr1(read_addr1), .read_addr2(read_addr2), .pause(pause)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 0;
    mem_valid = 1; alu_valid = 1; md_valid = 1;
    mem_addr = 5'd1; alu_addr = 5'd2; md_addr = 5'd3;
    mem_data = 32'h11; alu_data = 32'h22; md_data = 32'h33;
    issue_valid = 1; issue_addr = 5'd5; read_addr1 = 5'd5; read_addr2 = 5'd5;
    tick; tick;
    checks++; if (RegWE !== 1'b0) begin errors++; $display("FAIL reset_we got=%b want=0", RegWE); end
    checks++; if (write_addr !== 5'd0) begin errors++; $display("FAIL reset_addr got=%0d want=0", write_addr); end
    checks++; if (write_data !== 32'd0) begin errors++; $display("FAIL reset_data got=%h want=0", write_data); end
    checks++; if (pause !== 2'b00) begin errors++; $display("FAIL reset_pause got=%b want=00", pause); end
    checks++; if (issue_full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b want=0", issue_full); end
    checks++; if ({md_ready, alu_ready, mem_ready} !== 3'b001) begin errors++; $display("FAIL reset_ready got=%b want=001", {md_ready, alu_ready, mem_ready}); end
    mem_valid = 0; alu_valid = 0; md_valid = 0; issue_valid = 0;
    read_addr1 = 0; read_addr2 = 0;
    rst = 1;
    tick;
    checks++; if (pause !== 2'b00 || RegWE !== 1'b0) begin errors++; $display("FAIL post_reset got pause=%b we=%b want 00/0", pause, RegWE); end
  endtask

  task automatic test_priority;
    mem_valid = 1; mem_addr = 5'd5; mem_data = 32'hAAAA0001;
    alu_valid = 1; alu_addr = 5'd6; alu_data = 32'hBBBB0002;
    #1;
    checks++; if ({md_ready, alu_ready, mem_ready} !== 3'b001) begin errors++; $display("FAIL prio_grant got=%b want=001", {md_ready, alu_ready, mem_ready}); end
    tick;
    mem_valid = 0;
    #1;
    checks++; if (RegWE !== 1'b1 || write_addr !== 5'd5 || write_data !== 32'hAAAA0001) begin errors++; $display("FAIL prio_write1 got we=%b a=%0d d=%h want 1/5/aaaa0001", RegWE, write_addr, write_data); end
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL prio_alu_ready got=%b want=1", alu_ready); end
    tick;
    alu_valid = 0;
    checks++; if (RegWE !== 1'b1 || write_addr !== 5'd6 || write_data !== 32'hBBBB0002) begin errors++; $display("FAIL prio_write2 got we=%b a=%0d d=%h want 1/6/bbbb0002", RegWE, write_addr, write_data); end
    tick;
    checks++; if (RegWE !== 1'b0 || write_addr !== 5'd6 || write_data !== 32'hBBBB0002) begin errors++; $display("FAIL prio_hold got we=%b a=%0d d=%h want 0/6/bbbb0002", RegWE, write_addr, write_data); end
  endtask

  task automatic test_starvation;
    mem_valid = 1; mem_addr = 5'd10; mem_data = 32'h100;
    alu_valid = 1; alu_addr = 5'd11; alu_data = 32'h200;
    md_valid = 1; md_addr = 5'd9; md_data = 32'h9999;
    for (int c = 1; c <= 4; c++) begin
      #1;
      checks++; if (md_ready !== 1'b0 || mem_ready !== 1'b1) begin errors++; $display("FAIL starve_wait%0d got md=%b mem=%b want 0/1", c, md_ready, mem_ready); end
      tick;
    end
    checks++; if (md_ready !== 1'b1 || mem_ready !== 1'b0 || alu_ready !== 1'b0) begin errors++; $display("FAIL starve_md_grant got md=%b alu=%b mem=%b want 1/0/0", md_ready, alu_ready, mem_ready); end
    tick;
    md_valid = 0;
    #1;
    checks++; if (RegWE !== 1'b1 || write_addr !== 5'd9 || write_data !== 32'h9999) begin errors++; $display("FAIL starve_md_write got we=%b a=%0d d=%h want 1/9/9999", RegWE, write_addr, write_data); end
    checks++; if (alu_ready !== 1'b1 || mem_ready !== 1'b0) begin errors++; $display("FAIL starve_alu_grant got alu=%b mem=%b want 1/0", alu_ready, mem_ready); end
    tick;
    md_valid = 1;
    #1;
    checks++; if (md_ready !== 1'b0 || mem_ready !== 1'b1) begin errors++; $display("FAIL starve_cleared got md=%b mem=%b want 0/1", md_ready, mem_ready); end
    mem_valid = 0; alu_valid = 0; md_valid = 0;
    tick; tick;
  endtask

  task automatic test_scoreboard;
    issue_valid = 1; issue_addr = 5'd7; read_addr1 = 5'd7;
    #1;
    checks++; if (pause !== 2'b00) begin errors++; $display("FAIL sb_before_issue got=%b want=00", pause); end
    tick;
    issue_valid = 0;
    #1;
    checks++; if (pause !== 2'b01) begin errors++; $display("FAIL sb_pending got=%b want=01", pause); end
    tick;
    alu_valid = 1; alu_addr = 5'd7; alu_data = 32'h77;
    #1;
    checks++; if (pause !== 2'b01 || alu_ready !== 1'b1) begin errors++; $display("FAIL sb_grant got pause=%b ready=%b want 01/1", pause, alu_ready); end
    tick;
    alu_valid = 0; read_addr2 = 5'd7;
    #1;
    checks++; if (RegWE !== 1'b1 || write_addr !== 5'd7 || pause !== 2'b11) begin errors++; $display("FAIL sb_commit_cycle got we=%b a=%0d pause=%b want 1/7/11", RegWE, write_addr, pause); end
    tick;
    checks++; if (pause !== 2'b00) begin errors++; $display("FAIL sb_release got=%b want=00", pause); end
    read_addr1 = 0; read_addr2 = 0;
  endtask

  task automatic test_saturation;
    issue_valid = 1; issue_addr = 5'd3; read_addr1 = 5'd3;
    for (int n = 1; n <= 3; n++) begin
      #1;
      checks++; if (issue_full !== 1'b0) begin errors++; $display("FAIL sat_issue%0d got full=%b want=0", n, issue_full); end
      tick;
    end
    checks++; if (issue_full !== 1'b1) begin errors++; $display("FAIL sat_full got=%b want=1", issue_full); end
    tick;
    issue_valid = 0;
    mem_valid = 1; mem_addr = 5'd3; mem_data = 32'h333;
    tick; tick; tick;
    mem_valid = 0;
    #1;
    checks++; if (pause !== 2'b01 || RegWE !== 1'b1) begin errors++; $display("FAIL sat_two_commits got pause=%b we=%b want 01/1", pause, RegWE); end
    tick;
    checks++; if (pause !== 2'b00) begin errors++; $display("FAIL sat_release got=%b want=00", pause); end
    read_addr1 = 0;
  endtask

  task automatic test_boundaries;
    mem_valid = 1; mem_addr = 5'd0; mem_data = 32'hDEAD;
    #1;
    checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL r0_ready got=%b want=1", mem_ready); end
    tick;
    mem_valid = 0;
    checks++; if (RegWE !== 1'b0 || write_addr !== 5'd3 || write_data !== 32'h333) begin errors++; $display("FAIL r0_write got we=%b a=%0d d=%h want 0/3/333", RegWE, write_addr, write_data); end
    issue_valid = 1; issue_addr = 5'd4; read_addr1 = 5'd4;
    tick;
    issue_valid = 0;
    alu_valid = 1; alu_addr = 5'd4; alu_data = 32'h44;
    tick;
    alu_valid = 0;
    issue_valid = 1; issue_addr = 5'd4;
    tick;
    issue_valid = 0;
    checks++; if (pause !== 2'b01) begin errors++; $display("FAIL same_edge_kept got=%b want=01", pause); end
    alu_valid = 1;
    tick;
    alu_valid = 0;
    checks++; if (pause !== 2'b01 || RegWE !== 1'b1) begin errors++; $display("FAIL same_edge_commit got pause=%b we=%b want 01/1", pause, RegWE); end
    tick;
    checks++; if (pause !== 2'b00) begin errors++; $display("FAIL same_edge_release got=%b want=00", pause); end
    issue_valid = 1; issue_addr = 5'd0; read_addr1 = 5'd0; read_addr2 = 5'd0;
    #1;
    checks++; if (issue_full !== 1'b0) begin errors++; $display("FAIL r0_full got=%b want=0", issue_full); end
    tick;
    issue_valid = 0;
    checks++; if (pause !== 2'b00) begin errors++; $display("FAIL r0_pause got=%b want=00", pause); end
  endtask

  initial begin
    test_reset;
    test_priority;
    test_starvation;
    test_scoreboard;
    test_saturation;
    test_boundaries;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port arbiter and pending-write scoreboard for the 32x32 general register file. Shares the single register-file write port among three writeback requesters (MEM load, ALU, multi-cycle MULDIV) and registers the winning write onto RegWE/write_addr/write_data. Tracks outstanding destination writes per register and raises the decode-stage `pause` code while a source operand is still in flight, replacing fixed-depth address-history hazard detection.

## Interface
Parameters:
- STARVE_LIMIT, 4, consecutive lost cycles after which a requester is promoted to top priority (1..7).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous active-low reset.
- mem_valid / alu_valid / md_valid  in  1 each  requester has a write pending.
- mem_addr / alu_addr / md_addr  in  5 each  destination register.
- mem_data / alu_data / md_data  in  32 each  write value.
- mem_ready / alu_ready / md_ready  out  1 each  grant; transfer when valid && ready.
- RegWE  out  1  register-file write enable (registered).
- write_addr  out  5  register-file write address (registered).
- write_data  out  32  register-file write data (registered).
- issue_valid  in  1  decode issues an instruction with a destination.
- issue_addr  in  5  destination of issued instruction.
- issue_full  out  1  issue_addr already has 3 writes outstanding; issue not accepted.
- read_addr1 / read_addr2  in  5 each  decode-stage rs / rt.
- pause  out  2  00 none, 01 rs, 10 rt, 11 both.

## Operation
- Arbitration: combinational each cycle among valid requesters; at most one ready high.
- Base priority: mem > alu > md.
- Per-requester 3-bit wait counter: increments (saturating at STARVE_LIMIT) when valid && !ready; clears on grant or when not valid.
- Any requester with wait == STARVE_LIMIT is starved; starved requesters beat non-starved; among starved, md > alu > mem.
- ready never asserted to a non-valid requester.
- Accepted transfer with addr != 0: next cycle RegWE=1, write_addr/write_data = accepted values. addr == 0: accepted (ready high, consumed), RegWE stays 0, scoreboard unchanged.
- No transfer: RegWE=0 next cycle; write_addr/write_data hold last values.
- Scoreboard: 2-bit pending count per register 1..31 (reg 0 always 0).
  - issue_valid && issue_addr != 0 && count < 3: increment at edge.
  - count == 3 for issue_addr: issue_full=1 (combinational), no increment; decode must stall.
  - Commit: at an edge with RegWE=1, decrement count[write_addr] (saturate at 0).
  - Increment and commit same register same edge: count unchanged.
- pause: rs bit = (read_addr1 != 0 && count[read_addr1] != 0); rt bit likewise for read_addr2. Combinational from count state.
- Register-file write is synchronous: in the RegWE cycle the count is still nonzero, so readers pause; next cycle count reaches 0 and the read returns the new value.

## Timing
- Reset (rst=0 at edge): RegWE=0, write_addr=0, write_data=0, all counts 0, wait counters 0. Outputs after reset: all ready follow valid arbitration, pause=00, issue_full=0.
- Reset has priority over all updates; transfer accepted in a reset cycle is discarded; requesters re-present.
- Grant-to-write latency: 1 cycle. Throughput: one write per cycle.
- Issue-to-pause latency: 1 cycle (count visible after edge).
- Commit-to-pause-release: pause drops the cycle after RegWE=1.
- Requesters must hold valid/addr/data stable until ready.

## Test plan
- Reset: rst=0 two cycles with all valids high -> RegWE=0, write_addr=0, pause=00, counts 0.
- Priority: mem(r5,0xAAAA0001), alu(r6,0xBBBB0002) valid same cycle -> mem_ready=1, next cycle RegWE=1 addr 5 data 0xAAAA0001; alu granted the following cycle.
- Starvation: mem and alu valid every cycle, md(r9) valid -> md_ready on its 5th valid cycle (STARVE_LIMIT=4), then wait clears.
- Scoreboard: issue r7, read_addr1=7 -> pause=01 until cycle after alu write to r7 commits, then 00; read_addr1=read_addr2=7 -> 11.
- Saturation: issue r3 three times, no commits -> fourth issue_full=1, count stays 3; three commits -> pause releases.
- Boundaries: write to r0 consumed with RegWE=0; issue r4 and commit r4 same edge -> count unchanged; read_addr 0 never pauses.
